control_flag_bank: RTL

//  Parametrised bank of N_FLAG set/reset control-cycle flip-flops. Replaces the fixed
//  M1/MREQ/BUSRQ/NMI/INT flag groups. Adds per-group clears, one-shot flags that

---
 rtl/control_flag_bank_if.sv | 32 +++
 rtl/control_flag_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/control_flag_bank_if.sv
// control_flag_bank_if
//   Groups the request inputs, flag outputs and acknowledge handshake of
//   control_flag_bank.
//   master : P2-phase decode logic plus the consumer of acknowledge offers.
//            It drives P2_Set, P2_Reset, P2_Reset_Group, P2_Reset_ALL and Req_Ack.
//   slave  : the flag bank. It drives Q, notQ, Req_Valid and Req_Index.
interface control_flag_bank_if #(
  parameter int N_FLAG  = 16,
  parameter int N_GROUP = 4
);
  localparam int IDX_W = (N_FLAG > 1) ? $clog2(N_FLAG) : 1;

  logic [N_FLAG-1:0]  P2_Set;
  logic [N_FLAG-1:0]  P2_Reset;
  logic [N_GROUP-1:0] P2_Reset_Group;
  logic               P2_Reset_ALL;
  logic [N_FLAG-1:0]  Q;
  logic [N_FLAG-1:0]  notQ;
  logic               Req_Valid;
  logic [IDX_W-1:0]   Req_Index;
  logic               Req_Ack;

  modport master (
    output P2_Set, P2_Reset, P2_Reset_Group, P2_Reset_ALL, Req_Ack,
    input  Q, notQ, Req_Valid, Req_Index
  );

  modport slave (
    input  P2_Set, P2_Reset, P2_Reset_Group, P2_Reset_ALL, Req_Ack,
    output Q, notQ, Req_Valid, Req_Index
  );
endinterface

// File: rtl/control_flag_bank.sv
// control_flag_bank
//   Parametrised bank of N_FLAG set/reset control-cycle flags, with
//   per-group clears, a masked clear-all, auto-clearing one-shot flags and a
//   priority acknowledge port that offers pending flags (lowest index first).
//   Ports:
//     Clk   : clock, all state changes on the rising edge
//     Reset : asynchronous active-high reset
//     bus   : control_flag_bank_if.slave
//             (P2_Set/P2_Reset/P2_Reset_Group/P2_Reset_ALL/Req_Ack in,
//              Q/notQ/Req_Valid/Req_Index out)
//   All outputs come straight from flops.
module control_flag_bank #(
  parameter int                         N_FLAG       = 16,
  parameter int                         N_GROUP      = 4,
  parameter logic [N_GROUP*N_FLAG-1:0]  GROUP_MASK   = '0,
  parameter logic [N_FLAG-1:0]          ALLCLR_MASK  = '1,
  parameter logic [N_FLAG-1:0]          RESET_VAL    = '0,
  parameter bit                         SET_WINS     = 1'b0,
  parameter logic [N_FLAG-1:0]          ONESHOT_MASK = '0,
  parameter int                         ONESHOT_LEN  = 2,
  parameter logic [N_FLAG-1:0]          ACK_MASK     = '0
) (
  input logic                 Clk,
  input logic                 Reset,
  control_flag_bank_if.slave  bus
);
  localparam int IDX_W = (N_FLAG > 1) ? $clog2(N_FLAG) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [N_FLAG-1:0]      q_q, q_d;
  logic [N_FLAG-1:0][7:0] cnt_q, cnt_d;
  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [N_FLAG-1:0] grp_clr;
  logic [N_FLAG-1:0] expire;
  logic [N_FLAG-1:0] ack_clr;
  logic [N_FLAG-1:0] clr_ord;
  logic [N_FLAG-1:0] clr_all;
  logic [N_FLAG-1:0] pend;
  logic [IDX_W-1:0]  lowest;
  logic              offered_live;

  // Clear sources
  always_comb begin
    grp_clr = '0;
    for (int g = 0; g < N_GROUP; g++) begin
      grp_clr = grp_clr |
                ({N_FLAG{bus.P2_Reset_Group[g]}} & GROUP_MASK[g*N_FLAG +: N_FLAG]);
    end
    for (int i = 0; i < N_FLAG; i++) begin
      // A one-shot expires on the edge where its count is 1, giving exactly
      // ONESHOT_LEN cycles high.
      expire[i]  = ONESHOT_MASK[i] & q_q[i] & (cnt_q[i] == 8'd1);
      ack_clr[i] = (state_q == ST_OFFER) & bus.Req_Ack & ACK_MASK[i] &
                   (idx_q == IDX_W'(i));
    end
    clr_ord = bus.P2_Reset | grp_clr | ack_clr | expire;
    clr_all = {N_FLAG{bus.P2_Reset_ALL}} & ALLCLR_MASK;
  end

  // Next flag state and one-shot counters
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_FLAG; i++) begin
      // Clear-all overrides set unconditionally; SET_WINS only arbitrates
      // against the ordinary clear sources.
      if (clr_all[i])
        q_d[i] = 1'b0;
      else if (bus.P2_Set[i] && clr_ord[i])
        q_d[i] = SET_WINS;
      else if (bus.P2_Set[i])
        q_d[i] = 1'b1;
      else if (clr_ord[i])
        q_d[i] = 1'b0;

      if (!ONESHOT_MASK[i] || !q_d[i])
        cnt_d[i] = 8'd0;
      else if (bus.P2_Set[i])
        cnt_d[i] = 8'(ONESHOT_LEN);   // load on set, reload on retrigger
      else if (q_q[i] && (cnt_q[i] != 8'd0))
        cnt_d[i] = cnt_q[i] - 8'd1;
    end
  end

  // Acknowledge FSM
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend         = q_q & ACK_MASK;
    lowest       = '0;
    offered_live = 1'b0;
    for (int i = N_FLAG - 1; i >= 0; i--) begin
      if (pend[i]) lowest = IDX_W'(i);
    end
    // Withdraw is judged on the next flag state so Req_Valid falls on the
    // same edge the offered flag is cleared.
    for (int i = 0; i < N_FLAG; i++) begin
      if (idx_q == IDX_W'(i)) offered_live = q_d[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (pend != '0) begin
          state_d = ST_OFFER;
          idx_d   = lowest;
        end
      end
      default: begin
        if (bus.Req_Ack || !offered_live) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.notQ      = ~q_q;
  assign bus.Req_Valid = (state_q == ST_OFFER);
  assign bus.Req_Index = idx_q;

endmodule
